eda_region_scan_ctrl: RTL and testbench
=======================================

EDA_REGION_SCAN_CTRL -- requirements
Module: eda_region_scan_ctrl

Interface
REQ-001 The module SHALL have parameters M (CFG_M), N (CFG_N), WINDOW_WIDTH (CFG_WINDOW_WIDTH, 9), ADDR_WIDTH (CFG_ADDR_WIDTH), I_WIDTH (CFG_I_WIDTH) and J_WIDTH (CFG_J_WIDTH), plus STACK_DEPTH (default 16, pending-pixel LIFO depth).
REQ-002 The module SHALL use one clock and an asynchronous active-low reset, with ports ordered as listed below.
- clk  in  1  clock, rising edge
- reset_n  in  1  async active-low reset
- start  in  1  begin full-image scan
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at scan end
- region_start  out  1  one-cycle pulse when a new seed is taken
- region_done  out  1  one-cycle pulse when a region's stack empties
- stack_overflow  out  1  sticky error flag
- ram_clear  out  1  clear iterated RAM
- ram_new_pixel  out  1  mark center visited
- ram_center_addr  out  ADDR_WIDTH  {i,j} current pixel
- ram_nb_addr  out  8xADDR_WIDTH  neighbour addresses; bit7 upleft, 6 up, 5 upright, 4 left, 3 right, 2 downleft, 1 down, 0 downright
- ram_neigh_addr_valid  out  8  in-image mask, same bit order
- ram_push_positions  out  8  neighbours to mark visited
- ram_iterated_idx  in  8  visited flags of neighbours
- ram_next_row  in  I_WIDTH  first unvisited row
- ram_next_col  in  J_WIDTH  first unvisited column
- ram_iterated_all  in  1  all pixels visited
- eval_valid  out  1  request neighbour evaluation of ram_center_addr
- eval_ready  in  1  evaluator accepts
- eval_push  in  8  neighbours belonging to current region

Function
REQ-003 States SHALL be IDLE, CLEAR, SEED, POP, EVAL, PUSH, REND.
REQ-004 IDLE: start=1 -> CLEAR; start while busy SHALL be ignored.
REQ-005 CLEAR: ram_clear=1 for exactly one cycle, then SEED.
REQ-006 SEED: if ram_iterated_all=1 -> done=1 for one cycle, then IDLE; otherwise ram_center_addr={ram_next_row,ram_next_col}, ram_new_pixel=1, region_start=1, push seed onto the stack, then POP.
REQ-007 POP: stack empty -> REND; otherwise pop top into cur_addr, then EVAL.
REQ-008 EVAL: ram_center_addr=cur_addr, eval_valid=1 held until eval_ready=1; cur_addr and neighbour outputs SHALL be stable while eval_valid=1.
REQ-009 On the eval_valid&eval_ready cycle, mask = eval_push & ram_neigh_addr_valid & ~ram_iterated_idx SHALL be driven on ram_push_positions in that cycle only and latched; then PUSH.
REQ-010 PUSH: latched mask bits SHALL be pushed one per cycle, highest index first; after the last bit (or immediately if the mask is zero) -> POP.
REQ-011 REND: region_done=1 for one cycle, then SEED.
REQ-012 Neighbour i/j SHALL be computed as i+-1, j+-1 without wrap: up-row invalid if i=0, down-row if i=M-1, left-col if j=0, right-col if j=N-1; invalid addresses SHALL be driven 0.
REQ-013 ram_neigh_addr_valid SHALL be 0 outside EVAL; ram_push_positions SHALL be 0 except at the REQ-009 cycle.
REQ-014 Push while stack holds STACK_DEPTH entries SHALL drop the entry and set stack_overflow, which stays set until the next start or reset; the scan continues.
REQ-015 busy SHALL be 1 in every state except IDLE, and SHALL be 0 in the cycle after done.

Reset
REQ-016 reset_n=0 SHALL force IDLE, empty stack, and all outputs 0 (including stack_overflow) immediately, including mid-scan.
REQ-017 After reset release, the block SHALL act only on a new start.

Verification
REQ-018 M=N=4, all evaluator eval_push=0, start -> 16 region_start and 16 region_done pulses, then done; ram_clear pulsed once.
REQ-019 Same image, eval_push=8'hFF always -> exactly one region_start, 16 ram_new_pixel/push marks in total, region_done once, then done.
REQ-020 Center at {0,0} -> ram_neigh_addr_valid=8'b0000_1011; center at {3,3} -> 8'b1101_0000.
REQ-021 eval_ready held low for 5 cycles -> eval_valid and ram_center_addr stable for all 5 cycles; no ram_push_positions until ready.
REQ-022 STACK_DEPTH=2, eval_push=8'hFF, 4x4 image -> stack_overflow=1 and done still pulses; next start clears the flag.
REQ-023 reset_n asserted during PUSH -> busy=0 and stack empty; a following start scans from CLEAR normally.

Source files
------------

// File: rtl/eda_region_scan_ctrl.sv
// eda_region_scan_ctrl: flood-fill region scanner over an M x N image.
// Ports: clk/reset_n, start/busy/done, region pulses, sticky stack_overflow,
//   visited-RAM control (clear, new pixel, center/neighbour addresses,
//   valid and push masks, visited flags, next unvisited pixel),
//   evaluator handshake (eval_valid/eval_ready, eval_push).
module eda_region_scan_ctrl #(
    parameter int M            = 4,
    parameter int N            = 4,
    parameter int WINDOW_WIDTH = 9,
    parameter int ADDR_WIDTH   = 4,
    parameter int I_WIDTH      = 2,
    parameter int J_WIDTH      = 2,
    parameter int STACK_DEPTH  = 16
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    start,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    region_start,
    output logic                                    region_done,
    output logic                                    stack_overflow,
    output logic                                    ram_clear,
    output logic                                    ram_new_pixel,
    output logic [ADDR_WIDTH-1:0]                   ram_center_addr,
    output logic [(WINDOW_WIDTH-1)*ADDR_WIDTH-1:0]  ram_nb_addr,
    output logic [WINDOW_WIDTH-2:0]                 ram_neigh_addr_valid,
    output logic [WINDOW_WIDTH-2:0]                 ram_push_positions,
    input  logic [WINDOW_WIDTH-2:0]                 ram_iterated_idx,
    input  logic [I_WIDTH-1:0]                      ram_next_row,
    input  logic [J_WIDTH-1:0]                      ram_next_col,
    input  logic                                    ram_iterated_all,
    output logic                                    eval_valid,
    input  logic                                    eval_ready,
    input  logic [WINDOW_WIDTH-2:0]                 eval_push
);

    localparam int NB   = WINDOW_WIDTH - 1;
    localparam int SPW  = $clog2(STACK_DEPTH + 1);
    localparam int IXW  = $clog2(STACK_DEPTH);
    localparam int SELW = $clog2(NB);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_SEED, S_POP, S_EVAL, S_PUSH, S_REND
    } state_t;

    state_t                 state_q, state_d;
    logic [SPW-1:0]         sp_q, sp_d;
    logic [ADDR_WIDTH-1:0]  cur_q, cur_d;
    logic [NB-1:0]          mask_q, mask_d;
    logic                   ovf_q, ovf_d;
    logic [ADDR_WIDTH-1:0]  stack_q [STACK_DEPTH];

    logic                   push_en;
    logic [ADDR_WIDTH-1:0]  push_addr;
    logic                   full;

    logic [I_WIDTH-1:0]     i_c, i_up, i_dn;
    logic [J_WIDTH-1:0]     j_c, j_lf, j_rt;
    logic                   up_ok, dn_ok, lf_ok, rt_ok;
    logic [NB-1:0]          nb_ok;
    logic [ADDR_WIDTH-1:0]  nb_a [NB];
    logic [NB-1:0]          hs_mask;
    logic [SELW-1:0]        sel;
    logic                   in_eval;

    // Neighbour geometry of the current pixel; edges never wrap.
    assign i_c   = cur_q[ADDR_WIDTH-1:J_WIDTH];
    assign j_c   = cur_q[J_WIDTH-1:0];
    assign i_up  = i_c - I_WIDTH'(1);
    assign i_dn  = i_c + I_WIDTH'(1);
    assign j_lf  = j_c - J_WIDTH'(1);
    assign j_rt  = j_c + J_WIDTH'(1);
    assign up_ok = (i_c != '0);
    assign dn_ok = (i_c != I_WIDTH'(M - 1));
    assign lf_ok = (j_c != '0);
    assign rt_ok = (j_c != J_WIDTH'(N - 1));

    assign nb_ok = {up_ok & lf_ok, up_ok, up_ok & rt_ok, lf_ok,
                    rt_ok, dn_ok & lf_ok, dn_ok, dn_ok & rt_ok};

    assign nb_a[7] = {i_up, j_lf};
    assign nb_a[6] = {i_up, j_c};
    assign nb_a[5] = {i_up, j_rt};
    assign nb_a[4] = {i_c,  j_lf};
    assign nb_a[3] = {i_c,  j_rt};
    assign nb_a[2] = {i_dn, j_lf};
    assign nb_a[1] = {i_dn, j_c};
    assign nb_a[0] = {i_dn, j_rt};

    assign in_eval              = (state_q == S_EVAL);
    assign ram_neigh_addr_valid = in_eval ? nb_ok : '0;
    assign hs_mask              = eval_push & nb_ok & ~ram_iterated_idx;
    assign busy                 = (state_q != S_IDLE);
    assign stack_overflow       = ovf_q;
    assign full                 = (sp_q == SPW'(STACK_DEPTH));

    for (genvar g = 0; g < NB; g++) begin : g_nb
        assign ram_nb_addr[g*ADDR_WIDTH +: ADDR_WIDTH] =
            (in_eval && nb_ok[g]) ? nb_a[g] : '0;
    end

    // Highest pending neighbour is pushed first.
    always_comb begin
        sel = '0;
        for (int k = 0; k < NB; k++) begin
            if (mask_q[k]) sel = SELW'(k);
        end
    end

    always_comb begin
        state_d            = state_q;
        sp_d               = sp_q;
        cur_d              = cur_q;
        mask_d             = mask_q;
        ovf_d              = ovf_q;
        push_en            = 1'b0;
        push_addr          = '0;
        done               = 1'b0;
        region_start       = 1'b0;
        region_done        = 1'b0;
        ram_clear          = 1'b0;
        ram_new_pixel      = 1'b0;
        ram_center_addr    = '0;
        ram_push_positions = '0;
        eval_valid         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ovf_d   = 1'b0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                ram_clear = 1'b1;
                state_d   = S_SEED;
            end
            S_SEED: begin
                if (ram_iterated_all) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    ram_center_addr = {ram_next_row, ram_next_col};
                    ram_new_pixel   = 1'b1;
                    region_start    = 1'b1;
                    push_en         = 1'b1;
                    push_addr       = {ram_next_row, ram_next_col};
                    state_d         = S_POP;
                end
            end
            S_POP: begin
                if (sp_q == '0) begin
                    state_d = S_REND;
                end else begin
                    cur_d   = stack_q[IXW'(sp_q - SPW'(1))];
                    sp_d    = sp_q - SPW'(1);
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                ram_center_addr = cur_q;
                eval_valid      = 1'b1;
                if (eval_ready) begin
                    ram_push_positions = hs_mask;
                    mask_d             = hs_mask;
                    state_d            = S_PUSH;
                end
            end
            S_PUSH: begin
                if (mask_q == '0) begin
                    state_d = S_POP;
                end else begin
                    push_en   = 1'b1;
                    push_addr = nb_a[sel];
                    mask_d    = mask_q & ~(NB'(1) << sel);
                    if (mask_d == '0) state_d = S_POP;
                end
            end
            S_REND: begin
                region_done = 1'b1;
                state_d     = S_SEED;
            end
            default: state_d = S_IDLE;
        endcase

        // A push into a full stack is dropped and flagged.
        if (push_en) begin
            if (full) ovf_d = 1'b1;
            else      sp_d  = sp_q + SPW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            sp_q    <= '0;
            cur_q   <= '0;
            mask_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            cur_q   <= cur_d;
            mask_q  <= mask_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en && !full) stack_q[IXW'(sp_q)] <= push_addr;
    end

endmodule

// File: tb/tb_eda_region_scan_ctrl.sv
// tb_eda_region_scan_ctrl: randomized scans of a 4x4 labelled image,
// checked against a flood-fill model; DUT A depth 16, DUT B depth 2.
module tb_eda_region_scan_ctrl;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int AW = 4;
    localparam int P  = M * N;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic start   = 1'b0;
    logic sel     = 1'b0;
    logic eval_ready = 1'b0;

    always #5 clk = ~clk;

    logic [7:0] iter_idx, eval_push;
    logic [1:0] next_row, next_col;
    logic       iter_all;
    logic       a_start, b_start;

    logic a_busy, a_done, a_rstart, a_rdone, a_ovf, a_clear, a_newpix, a_evalid;
    logic b_busy, b_done, b_rstart, b_rdone, b_ovf, b_clear, b_newpix, b_evalid;
    logic [AW-1:0]   a_center, b_center;
    logic [8*AW-1:0] a_nb, b_nb;
    logic [7:0]      a_nbv, b_nbv, a_pushpos, b_pushpos;

    logic x_busy, x_done, x_rstart, x_rdone, x_ovf, x_clear, x_newpix, x_evalid;
    logic [AW-1:0]   x_center;
    logic [8*AW-1:0] x_nb;
    logic [7:0]      x_nbv, x_pushpos;

    assign a_start = start & ~sel;
    assign b_start = start & sel;

    assign x_busy    = sel ? b_busy    : a_busy;
    assign x_done    = sel ? b_done    : a_done;
    assign x_rstart  = sel ? b_rstart  : a_rstart;
    assign x_rdone   = sel ? b_rdone   : a_rdone;
    assign x_ovf     = sel ? b_ovf     : a_ovf;
    assign x_clear   = sel ? b_clear   : a_clear;
    assign x_newpix  = sel ? b_newpix  : a_newpix;
    assign x_evalid  = sel ? b_evalid  : a_evalid;
    assign x_center  = sel ? b_center  : a_center;
    assign x_nb      = sel ? b_nb      : a_nb;
    assign x_nbv     = sel ? b_nbv     : a_nbv;
    assign x_pushpos = sel ? b_pushpos : a_pushpos;

    eda_region_scan_ctrl #(.M(4), .N(4), .STACK_DEPTH(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(a_start),
        .busy(a_busy), .done(a_done),
        .region_start(a_rstart), .region_done(a_rdone),
        .stack_overflow(a_ovf), .ram_clear(a_clear),
        .ram_new_pixel(a_newpix), .ram_center_addr(a_center),
        .ram_nb_addr(a_nb), .ram_neigh_addr_valid(a_nbv),
        .ram_push_positions(a_pushpos), .ram_iterated_idx(iter_idx),
        .ram_next_row(next_row), .ram_next_col(next_col),
        .ram_iterated_all(iter_all), .eval_valid(a_evalid),
        .eval_ready(eval_ready), .eval_push(eval_push)
    );

    eda_region_scan_ctrl #(.M(4), .N(4), .STACK_DEPTH(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start),
        .busy(b_busy), .done(b_done),
        .region_start(b_rstart), .region_done(b_rdone),
        .stack_overflow(b_ovf), .ram_clear(b_clear),
        .ram_new_pixel(b_newpix), .ram_center_addr(b_center),
        .ram_nb_addr(b_nb), .ram_neigh_addr_valid(b_nbv),
        .ram_push_positions(b_pushpos), .ram_iterated_idx(iter_idx),
        .ram_next_row(next_row), .ram_next_col(next_col),
        .ram_iterated_all(iter_all), .eval_valid(b_evalid),
        .eval_ready(eval_ready), .eval_push(eval_push)
    );

    bit visited [P];
    int color [P];
    bit ff_mode = 1'b0;
    int di [8] = '{1, 1, 1, 0, 0, -1, -1, -1};
    int dj [8] = '{1, 0, -1, 1, -1, 1, 0, -1};

    int vectors = 0;
    int errors  = 0;

    // Visited-map RAM
    always_comb begin
        iter_idx = '0;
        for (int k = 0; k < 8; k++)
            iter_idx[k] = visited[x_nb[k*AW +: AW]];
        next_row = '0;
        next_col = '0;
        iter_all = 1'b1;
        for (int p = P - 1; p >= 0; p--) begin
            if (!visited[p]) begin
                next_row = 2'(p / N);
                next_col = 2'(p % N);
                iter_all = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (x_clear)
            for (int p = 0; p < P; p++) visited[p] <= 1'b0;
        if (x_newpix) visited[x_center] <= 1'b1;
        for (int k = 0; k < 8; k++)
            if (x_pushpos[k]) visited[x_nb[k*AW +: AW]] <= 1'b1;
    end

    // Evaluator: neighbour joins when it has the same label.
    always_comb begin : evaluator
        int ci, cj, ni, nj;
        eval_push = '0;
        ci = int'(x_center) / N;
        cj = int'(x_center) % N;
        for (int k = 0; k < 8; k++) begin
            ni = ci + di[k];
            nj = cj + dj[k];
            if (ff_mode)
                eval_push[k] = 1'b1;
            else if (ni >= 0 && ni < M && nj >= 0 && nj < N)
                eval_push[k] = (color[ni*N+nj] == color[ci*N+cj]);
        end
    end

    int ref_q[$];

    function automatic void ref_regions();
        bit lbl [P];
        int st[$];
        int c, n, ni, nj, sz;
        ref_q.delete();
        for (int p = 0; p < P; p++) lbl[p] = 1'b0;
        for (int p = 0; p < P; p++) begin
            if (!lbl[p]) begin
                sz = 0;
                lbl[p] = 1'b1;
                st.push_back(p);
                while (st.size() > 0) begin
                    c = st.pop_back();
                    sz++;
                    for (int k = 0; k < 8; k++) begin
                        ni = c / N + di[k];
                        nj = c % N + dj[k];
                        if (ni >= 0 && ni < M && nj >= 0 && nj < N) begin
                            n = ni * N + nj;
                            if (!lbl[n] && (ff_mode || color[n] == color[c])) begin
                                lbl[n] = 1'b1;
                                st.push_back(n);
                            end
                        end
                    end
                end
                ref_q.push_back(sz);
            end
        end
    endfunction

    int n_rstart, n_rdone, n_done, n_clear, n_marks, n_evals, n_stall;
    int sizes[$];
    bit ovf_end, ovf_at_clear, got_done;
    logic [7:0] nbv0, nbv15;

    task automatic run_scan(input bit use_b, input int wait_fix, input bit mid_start);
        int cur_sz, wcnt, ni, nj, ci, cj;
        bit in_ev, prev_stall, seen_done;
        logic [AW-1:0] prev_c;
        logic [8*AW-1:0] prev_nb, nbref;
        logic [7:0] vref, mref;
        n_rstart = 0; n_rdone = 0; n_done = 0; n_clear = 0;
        n_marks = 0; n_evals = 0; n_stall = 0;
        sizes.delete();
        got_done = 0; ovf_end = 0; ovf_at_clear = 1;
        nbv0 = '0; nbv15 = '0;
        cur_sz = 0; wcnt = 0; in_ev = 0; prev_stall = 0; seen_done = 0;
        prev_c = '0; prev_nb = '0;
        sel = use_b;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
            @(negedge clk);
            start = mid_start && (cyc == 20);
            if (x_evalid) begin
                if (!in_ev) begin
                    in_ev = 1;
                    wcnt = (wait_fix >= 0) ? wait_fix : int'($urandom_range(0, 6));
                end
                eval_ready = (wcnt == 0);
                if (wcnt > 0) wcnt--;
            end else begin
                in_ev = 0;
                eval_ready = 1'b0;
            end
            #1;
            if (seen_done) begin
                vectors++;
                if (x_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_after_done got %b want 0", x_busy);
                end
                got_done = 1;
            end
            ci = int'(x_center) / N;
            cj = int'(x_center) % N;
            vref = '0;
            mref = '0;
            nbref = '0;
            for (int k = 0; k < 8; k++) begin
                ni = ci + di[k];
                nj = cj + dj[k];
                if (ni >= 0 && ni < M && nj >= 0 && nj < N) begin
                    vref[k] = 1'b1;
                    nbref[k*AW +: AW] = AW'(ni * N + nj);
                    mref[k] = eval_push[k] && !visited[ni*N+nj];
                end
            end
            if (x_evalid) begin
                vectors++;
                if (x_nbv !== vref || x_nb !== nbref) begin
                    errors++;
                    $display("FAIL nb_addr c=%0d got %h/%h want %h/%h",
                             x_center, x_nbv, x_nb, vref, nbref);
                end
                if (prev_stall) begin
                    vectors++;
                    if (x_center !== prev_c || x_nb !== prev_nb) begin
                        errors++;
                        $display("FAIL eval_hold got %0d want %0d", x_center, prev_c);
                    end
                end
                if (x_center == 4'd0)  nbv0  = x_nbv;
                if (x_center == 4'd15) nbv15 = x_nbv;
            end else begin
                vectors++;
                if (x_nbv !== 8'h00) begin
                    errors++;
                    $display("FAIL nb_valid_idle got %h want 00", x_nbv);
                end
            end
            if (x_evalid && eval_ready) begin
                vectors++;
                if (x_pushpos !== mref) begin
                    errors++;
                    $display("FAIL push_mask c=%0d got %h want %h", x_center, x_pushpos, mref);
                end
                n_evals++;
                n_marks += $countones(x_pushpos);
                cur_sz  += $countones(x_pushpos);
            end else begin
                vectors++;
                if (x_pushpos !== 8'h00) begin
                    errors++;
                    $display("FAIL push_idle got %h want 00", x_pushpos);
                end
            end
            if (x_evalid && !eval_ready) n_stall++;
            prev_stall = x_evalid && !eval_ready;
            prev_c  = x_center;
            prev_nb = x_nb;
            if (x_clear) begin
                n_clear++;
                ovf_at_clear = x_ovf;
            end
            if (x_newpix) n_marks++;
            if (x_rstart) begin
                n_rstart++;
                cur_sz = 1;
            end
            if (x_rdone) begin
                n_rdone++;
                sizes.push_back(cur_sz);
            end
            if (x_done) begin
                n_done++;
                ovf_end = x_ovf;
                seen_done = 1;
            end
        end
        start = 1'b0;
        eval_ready = 1'b0;
        vectors++;
        if (!got_done) begin
            errors++;
            $display("FAIL scan_timeout got no done want done");
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        sel = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({a_busy, a_done, a_rstart, a_rdone, a_ovf, a_clear, a_newpix, a_evalid} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctl_a got %b want 0", {a_busy, a_done, a_ovf, a_evalid});
        end
        vectors++;
        if ({a_center, a_nb, a_nbv, a_pushpos} !== '0) begin
            errors++;
            $display("FAIL reset_addr_a got %h want 0", a_nb);
        end
        vectors++;
        if ({b_busy, b_done, b_ovf, b_clear, b_evalid, b_nbv, b_pushpos} !== '0) begin
            errors++;
            $display("FAIL reset_b got %b want 0", {b_busy, b_ovf});
        end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        vectors++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0 || a_clear !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start got %b%b want 00", a_busy, b_busy);
        end
    endtask

    task automatic check_counts(input string nm, input int got, input int want);
        vectors++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic test_isolated();
        ff_mode = 1'b0;
        for (int p = 0; p < P; p++) color[p] = p;
        run_scan(1'b0, -1, 1'b0);
        check_counts("iso_region_start", n_rstart, 16);
        check_counts("iso_region_done", n_rdone, 16);
        check_counts("iso_done", n_done, 1);
        check_counts("iso_clear", n_clear, 1);
        check_counts("iso_marks", n_marks, 16);
        check_counts("iso_evals", n_evals, 16);
        vectors++;
        if (nbv0 !== 8'b0000_1011) begin
            errors++;
            $display("FAIL corner00_valid got %b want 00001011", nbv0);
        end
        vectors++;
        if (nbv15 !== 8'b1101_0000) begin
            errors++;
            $display("FAIL corner33_valid got %b want 11010000", nbv15);
        end
    endtask

    task automatic test_flood();
        ff_mode = 1'b1;
        for (int p = 0; p < P; p++) color[p] = 0;
        run_scan(1'b0, -1, 1'b0);
        check_counts("flood_region_start", n_rstart, 1);
        check_counts("flood_region_done", n_rdone, 1);
        check_counts("flood_marks", n_marks, 16);
        check_counts("flood_done", n_done, 1);
        check_counts("flood_evals", n_evals, 16);
        check_counts("flood_ovf", int'(ovf_end), 0);
        ff_mode = 1'b0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            ff_mode = 1'b0;
            for (int p = 0; p < P; p++) color[p] = int'($urandom_range(0, 1));
            ref_regions();
            run_scan(1'b0, -1, it == 0);
            check_counts("rnd_clear", n_clear, 1);
            check_counts("rnd_regions", n_rstart, ref_q.size());
            check_counts("rnd_marks", n_marks, 16);
            check_counts("rnd_evals", n_evals, 16);
            vectors++;
            if (sizes.size() != ref_q.size()) begin
                errors++;
                $display("FAIL rnd_size_count got %0d want %0d", sizes.size(), ref_q.size());
            end else begin
                foreach (ref_q[i]) begin
                    vectors++;
                    if (sizes[i] != ref_q[i]) begin
                        errors++;
                        $display("FAIL rnd_size[%0d] got %0d want %0d", i, sizes[i], ref_q[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_stall();
        ff_mode = 1'b0;
        for (int p = 0; p < P; p++) color[p] = int'($urandom_range(0, 1));
        ref_regions();
        run_scan(1'b0, 5, 1'b0);
        check_counts("stall_evals", n_evals, 16);
        check_counts("stall_cycles", n_stall, 5 * n_evals);
        check_counts("stall_regions", n_rstart, ref_q.size());
    endtask

    task automatic test_overflow();
        ff_mode = 1'b1;
        for (int p = 0; p < P; p++) color[p] = 0;
        run_scan(1'b1, -1, 1'b0);
        check_counts("ovf_set", int'(ovf_end), 1);
        check_counts("ovf_done", n_done, 1);
        check_counts("ovf_marks", n_marks, 16);
        check_counts("ovf_clear_first", int'(ovf_at_clear), 0);
        @(negedge clk);
        #1;
        check_counts("ovf_sticky", int'(b_ovf), 1);
        ff_mode = 1'b0;
        for (int p = 0; p < P; p++) color[p] = p;
        run_scan(1'b1, -1, 1'b0);
        check_counts("ovf_cleared_on_start", int'(ovf_at_clear), 0);
        check_counts("ovf_after_clean", int'(ovf_end), 0);
        check_counts("depth2_regions", n_rstart, 16);
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_push();
        bit hit;
        ff_mode = 1'b1;
        for (int p = 0; p < P; p++) color[p] = 0;
        sel = 1'b0;
        hit = 0;
        eval_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            #1;
            if (a_pushpos != 8'h00) hit = 1;
        end
        vectors++;
        if (!hit) begin
            errors++;
            $display("FAIL push_wait got none want handshake");
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({a_busy, a_evalid, a_ovf, a_clear, a_newpix} !== 5'b0 ||
            {a_center, a_nbv, a_pushpos} !== '0) begin
            errors++;
            $display("FAIL reset_in_push got %b want 0", {a_busy, a_evalid});
        end
        eval_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_counts("post_reset_idle", int'(a_busy), 0);
        ff_mode = 1'b0;
        for (int p = 0; p < P; p++) color[p] = p;
        run_scan(1'b0, -1, 1'b0);
        check_counts("post_reset_clear", n_clear, 1);
        check_counts("post_reset_evals", n_evals, 16);
        check_counts("post_reset_regions", n_rstart, 16);
    endtask

    initial begin
        test_reset();
        test_isolated();
        test_flood();
        test_stall();
        test_random();
        test_overflow();
        test_reset_mid_push();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
